// File: rtl/spi_rx_if.sv
// SPI receive bundle: arm/SCLK/MISO toward the shifter, word/done/count back.
// Latency: none, wires only.
// Backpressure: none; the master holds rx_en_i until it has read the word.
//
// Ports (slave view):
//   rx_en_i      arm/hold receive; low aborts a word in progress
//   SCLK_i       serial clock, synchronous to the system clock
//   MISO_i       serial data from the slave, asynchronous
//   rx_buffer_o  last completed word
//   rx_done_o    word complete (level)
//   bit_count_o  bits captured in the current word
interface spi_rx_if #(
    parameter int WIDTH = 8
);
    logic                           rx_en_i;
    logic                           SCLK_i;
    logic                           MISO_i;
    logic [WIDTH-1:0]               rx_buffer_o;
    logic                           rx_done_o;
    logic [$clog2(WIDTH+1)-1:0]     bit_count_o;

    modport master (
        output rx_en_i, SCLK_i, MISO_i,
        input  rx_buffer_o, rx_done_o, bit_count_o
    );

    modport slave (
        input  rx_en_i, SCLK_i, MISO_i,
        output rx_buffer_o, rx_done_o, bit_count_o
    );
endinterface

// File: rtl/spi_rx.sv
// SPI receive shifter: deserialises WIDTH bits MSB first from MISO on an SCLK edge.
// Latency: word and done visible 1 clock_i cycle after the detecting edge.
// Backpressure: holds the word in DONE until rx_en_i drops; later SCLK edges ignored.
//
// Ports:
//   clock_i  system clock
//   reset_i  synchronous, active-high reset
//   bus      spi_rx_if slave modport (rx_en_i, SCLK_i, MISO_i in;
//            rx_buffer_o, rx_done_o, bit_count_o out)
module spi_rx #(
    parameter int WIDTH       = 8,
    parameter bit SAMPLE_EDGE = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic     clock_i,
    input  logic     reset_i,
    spi_rx_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_miso_sync;
    logic                   r_sclk_q;
    logic [WIDTH-1:0]       r_shift;
    logic [WIDTH-1:0]       w_shift_nxt;
    logic [WIDTH-1:0]       r_buf;
    logic [WIDTH-1:0]       w_buf_nxt;
    logic                   r_done;
    logic                   w_done_nxt;
    logic [CW-1:0]          r_count;
    logic [CW-1:0]          w_count_nxt;
    logic                   w_miso_s;
    logic                   w_edge;
    logic [WIDTH-1:0]       w_shifted;

    assign w_miso_s  = r_miso_sync[SYNC_STAGES-1];
    assign w_shifted = {r_shift[WIDTH-2:0], w_miso_s};

    // sclk_q tracks SCLK_i in every state, so arming while SCLK already sits
    // at the sampling level cannot fabricate an edge.
    assign w_edge = SAMPLE_EDGE ? (bus.SCLK_i & ~r_sclk_q)
                                : (~bus.SCLK_i & r_sclk_q);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state     <= IDLE;
            r_miso_sync <= '0;
            r_sclk_q    <= 1'b0;
            r_shift     <= '0;
            r_buf       <= '0;
            r_done      <= 1'b0;
            r_count     <= '0;
        end else begin
            r_miso_sync[0] <= bus.MISO_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_miso_sync[i] <= r_miso_sync[i-1];
            end
            r_sclk_q <= bus.SCLK_i;
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_buf    <= w_buf_nxt;
            r_done   <= w_done_nxt;
            r_count  <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_buf_nxt   = r_buf;
        w_done_nxt  = r_done;
        w_count_nxt = r_count;
        case (r_state)
            IDLE: begin
                // An edge coinciding with arming is not captured.
                w_done_nxt  = 1'b0;
                w_count_nxt = '0;
                if (bus.rx_en_i) begin
                    w_state_nxt = SHIFT;
                    w_shift_nxt = '0;
                end
            end
            SHIFT: begin
                // Abort outranks a coincident sample edge.
                if (!bus.rx_en_i) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b0;
                    w_count_nxt = '0;
                end else if (w_edge) begin
                    w_shift_nxt = w_shifted;
                    w_count_nxt = r_count + CW'(1);
                    if (r_count == LAST_IDX) begin
                        w_buf_nxt   = w_shifted;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // Count stays saturated at WIDTH; edges are ignored here.
                if (!bus.rx_en_i) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b0;
                    w_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b0;
                w_count_nxt = '0;
            end
        endcase
    end

    assign bus.rx_buffer_o = r_buf;
    assign bus.rx_done_o   = r_done;
    assign bus.bit_count_o = r_count;
endmodule

// File: tb/tb_spi_rx.sv
module tb_spi_rx;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    spi_rx_if #(.WIDTH(8))  ifa ();
    spi_rx_if #(.WIDTH(24)) ifb ();

    spi_rx #(.WIDTH(8), .SAMPLE_EDGE(1'b0), .SYNC_STAGES(2)) u_dut_a (
        .clock_i (clk),
        .reset_i (rst_a),
        .bus     (ifa)
    );

    spi_rx #(.WIDTH(24), .SAMPLE_EDGE(1'b1), .SYNC_STAGES(3)) u_dut_b (
        .clock_i (clk),
        .reset_i (rst_b),
        .bus     (ifb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive/sample point: 1 time unit after the rising clock edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Mode-1 bits: MISO changes with SCLK rising, sampled on SCLK falling.
    task automatic send_a(input logic [7:0] d, input int nb);
        for (int i = 0; i < nb; i++) begin
            ifa.SCLK_i = 1'b1;
            ifa.MISO_i = d[7-i];
            tick(8);
            ifa.SCLK_i = 1'b0;
            tick(8);
        end
    endtask

    // Full byte with an exact latency check on the final falling edge.
    task automatic recv_a(input string tag, input logic [7:0] d);
        send_a(d, 7);
        ifa.SCLK_i = 1'b1;
        ifa.MISO_i = d[0];
        tick(8);
        ifa.SCLK_i = 1'b0;
        chk({tag, "_done_pre"}, {31'd0, ifa.rx_done_o}, 32'd0);
        tick(1);
        chk({tag, "_done"}, {31'd0, ifa.rx_done_o}, 32'd1);
        chk({tag, "_buf"}, {24'd0, ifa.rx_buffer_o}, {24'd0, d});
        chk({tag, "_cnt"}, {28'd0, ifa.bit_count_o}, 32'd8);
        tick(7);
    endtask

    initial begin
        logic [23:0] wb;
        wb = 24'h123456;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.rx_en_i = 1'b0; ifa.SCLK_i = 1'b0; ifa.MISO_i = 1'b0;
        ifb.rx_en_i = 1'b0; ifb.SCLK_i = 1'b0; ifb.MISO_i = 1'b0;
        tick(3);
        chk("rst_done", {31'd0, ifa.rx_done_o}, 32'd0);
        chk("rst_buf",  {24'd0, ifa.rx_buffer_o}, 32'd0);
        chk("rst_cnt",  {28'd0, ifa.bit_count_o}, 32'd0);
        rst_a = 1'b0;
        tick(2);

        // Mode-1 byte 0xA5.
        ifa.rx_en_i = 1'b1;
        tick(1);
        recv_a("a5", 8'hA5);

        // Extra SCLK periods after done with random MISO.
        for (int p = 0; p < 4; p++) begin
            ifa.SCLK_i = 1'b1;
            ifa.MISO_i = 1'($urandom_range(0, 1));
            tick(8);
            ifa.SCLK_i = 1'b0;
            tick(8);
            chk("xtra_done", {31'd0, ifa.rx_done_o}, 32'd1);
            chk("xtra_buf",  {24'd0, ifa.rx_buffer_o}, 32'hA5);
            chk("xtra_cnt",  {28'd0, ifa.bit_count_o}, 32'd8);
        end
        ifa.rx_en_i = 1'b0;
        tick(1);
        chk("drop_done", {31'd0, ifa.rx_done_o}, 32'd0);
        chk("drop_buf",  {24'd0, ifa.rx_buffer_o}, 32'hA5);
        chk("drop_cnt",  {28'd0, ifa.bit_count_o}, 32'd0);

        // Abort after 5 bits of 0x3C; 6th fall coincides with rx_en_i falling.
        ifa.rx_en_i = 1'b1;
        tick(1);
        send_a(8'h3C, 5);
        chk("abt_cnt5", {28'd0, ifa.bit_count_o}, 32'd5);
        chk("abt_done5", {31'd0, ifa.rx_done_o}, 32'd0);
        ifa.SCLK_i = 1'b1;
        ifa.MISO_i = 1'b1;
        tick(8);
        ifa.SCLK_i = 1'b0;
        ifa.rx_en_i = 1'b0;
        tick(1);
        chk("abt_cnt",  {28'd0, ifa.bit_count_o}, 32'd0);
        chk("abt_done", {31'd0, ifa.rx_done_o}, 32'd0);
        chk("abt_buf",  {24'd0, ifa.rx_buffer_o}, 32'hA5);
        tick(7);
        ifa.rx_en_i = 1'b1;
        tick(1);
        recv_a("3c", 8'h3C);

        // Falling edge in the same cycle as arming is not captured.
        ifa.rx_en_i = 1'b0;
        ifa.SCLK_i = 1'b1;
        tick(3);
        ifa.SCLK_i = 1'b0;
        ifa.rx_en_i = 1'b1;
        tick(1);
        chk("armedge_cnt", {28'd0, ifa.bit_count_o}, 32'd0);
        tick(8);
        chk("armedge_cnt2", {28'd0, ifa.bit_count_o}, 32'd0);
        recv_a("5a", 8'h5A);

        // Arm while SCLK high: first fall is bit 1, no phantom bit.
        ifa.rx_en_i = 1'b0;
        ifa.SCLK_i = 1'b1;
        tick(4);
        ifa.rx_en_i = 1'b1;
        tick(4);
        chk("armhi_cnt", {28'd0, ifa.bit_count_o}, 32'd0);
        recv_a("c3", 8'hC3);

        // Reset mid-word while rx_en_i stays high.
        ifa.rx_en_i = 1'b0;
        tick(1);
        ifa.rx_en_i = 1'b1;
        tick(1);
        send_a(8'h96, 3);
        chk("mid_cnt3", {28'd0, ifa.bit_count_o}, 32'd3);
        rst_a = 1'b1;
        tick(1);
        rst_a = 1'b0;
        chk("mid_done", {31'd0, ifa.rx_done_o}, 32'd0);
        chk("mid_buf",  {24'd0, ifa.rx_buffer_o}, 32'd0);
        chk("mid_cnt",  {28'd0, ifa.bit_count_o}, 32'd0);
        tick(1);
        recv_a("ff", 8'hFF);

        // WIDTH=24, rising-edge sampling, 3-stage synchroniser.
        rst_b = 1'b0;
        tick(2);
        ifb.rx_en_i = 1'b1;
        tick(1);
        for (int i = 0; i < 24; i++) begin
            ifb.MISO_i = wb[23-i];
            tick(4);
            ifb.SCLK_i = 1'b1;
            if (i == 23) begin
                chk("w24_done_pre", {31'd0, ifb.rx_done_o}, 32'd0);
                tick(1);
                chk("w24_done", {31'd0, ifb.rx_done_o}, 32'd1);
                tick(3);
            end else begin
                tick(4);
            end
            ifb.SCLK_i = 1'b0;
            if (i == 11) chk("w24_cnt12", {27'd0, ifb.bit_count_o}, 32'd12);
        end
        tick(2);
        chk("w24_buf", {8'd0, ifb.rx_buffer_o}, 32'h123456);
        chk("w24_cnt", {27'd0, ifb.bit_count_o}, 32'd24);
        chk("w24_done_hold", {31'd0, ifb.rx_done_o}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_rx.md
Name: spi_rx

Overview:
- SPI receive shifter; the counterpart of spi_tx on the MISO line.
- Deserialises WIDTH bits, MSB first, from MISO_i. Sampling is timed by the SCLK_i waveform, which the SPI master produces in the clock_i domain.
- Sits beside spi_tx under the SPI master FSM, which drives SCLK_i, arms the block with rx_en_i and reads rx_buffer_o once rx_done_o is high.

Parameters:
- WIDTH, 8, bits per received word; legal range 2 or more.
- SAMPLE_EDGE, 0, SCLK edge that samples MISO: 0 = falling (SPI mode 1, ADC default), 1 = rising.
- SYNC_STAGES, 2, flip-flop stages on MISO_i before sampling; legal range 1 or more.

Ports:
- clock_i  input  1  system clock.
- reset_i  input  1  synchronous, active-high reset.
- rx_en_i  input  1  arm/hold receive. Low aborts a transfer in progress.
- SCLK_i  input  1  serial clock, synchronous to clock_i.
- MISO_i  input  1  serial data from the slave. Asynchronous.
- rx_buffer_o  output  WIDTH  last completed word.
- rx_done_o  output  1  word complete. Level signal.
- bit_count_o  output  $clog2(WIDTH+1)  bits captured in the current word.

Behaviour:
- Reset, clock and reset: one clock, clock_i. reset_i is synchronous and active-high.
  - On reset_i: state=IDLE, shift register=0, bit count=0, rx_buffer_o=0, rx_done_o=0.
  - sclk_q and all MISO synchroniser stages reset to 0.
- MISO synchroniser:
  - MISO_i passes through SYNC_STAGES flip-flops to give miso_s.
  - MISO_i must be stable for at least SYNC_STAGES+1 clock_i cycles before the sample edge.
- Edge detection:
  - sclk_q <= SCLK_i every cycle, in every state including IDLE.
  - Sample edge: SCLK_i=0 and sclk_q=1 when SAMPLE_EDGE=0; SCLK_i=1 and sclk_q=0 when SAMPLE_EDGE=1.
  - Arming while SCLK_i is already at the sampling level produces no edge.
- IDLE:
  - rx_done_o=0 and bit_count_o=0. Sample edges are ignored.
  - rx_en_i=1 -> SHIFT, with shift register and count cleared.
- SHIFT:
  - On each sample edge: shift <= {shift[WIDTH-2:0], miso_s}, count += 1.
  - On the edge that makes count==WIDTH, at that same clock edge: rx_buffer_o <= {shift[WIDTH-2:0], miso_s}, rx_done_o <= 1, state -> DONE.
  - Latency: rx_done_o and rx_buffer_o are visible 1 clock_i cycle after the detecting edge.
  - rx_en_i=0 -> IDLE. Partial word discarded, rx_buffer_o unchanged, rx_done_o stays 0.
- DONE:
  - rx_done_o=1 and rx_buffer_o held. bit_count_o=WIDTH.
  - Further SCLK edges are ignored; no overrun and no second word.
  - rx_en_i=0 -> IDLE: rx_done_o drops next cycle, rx_buffer_o is retained.
- Boundaries:
  - rx_buffer_o changes only on completion of a word.
  - A sample edge in the same cycle that rx_en_i rises is not captured (the block is still in IDLE).
  - A sample edge in the same cycle that rx_en_i falls in SHIFT: abort wins, no shift.
  - reset_i mid-word behaves exactly as reset (above).
  - Reset dominates rx_en_i.
- Arithmetic:
  - Count is an unsigned value of $clog2(WIDTH+1) bits and saturates at WIDTH.
  - No wrap: DONE blocks further increments.

Test Plan:
- Mode-1 byte: WIDTH=8, SAMPLE_EDGE=0, SCLK half-period 8 clk, MISO presents 0xA5 MSB first and changes on rising edges -> rx_done_o=1 one cycle after the 8th falling edge, rx_buffer_o=0xA5, bit_count_o=8.
- Extra clocks: keep toggling SCLK for 4 more periods after done, MISO random -> rx_buffer_o stays 0xA5, rx_done_o stays 1. Drop rx_en_i -> rx_done_o=0 next cycle, buffer still 0xA5.
- Abort: arm, send 5 bits of 0x3C, drop rx_en_i -> rx_done_o never rises, buffer keeps its previous value. Re-arm and send 0x3C fully -> rx_buffer_o=0x3C.
- Arm while SCLK_i=1 (SAMPLE_EDGE=0): the first SCLK fall is counted as bit 1 -> after 8 falls rx_done_o=1 with the correct word, and no phantom bit.
- Reset mid-word: after 3 bits assert reset_i for 1 cycle -> all outputs 0, state IDLE. Then receive 0xFF -> rx_buffer_o=0xFF.
- WIDTH=24, SAMPLE_EDGE=1, SYNC_STAGES=3, MISO 0x123456 set up 4 clk before each rising edge -> rx_buffer_o=0x123456, bit_count_o=24.
